regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  req0 (ALU/EX result) and req1 (memory load).
//  - Round-robin arbitration with valid/ready handshakes; the winner is registered into a write stage.
//  - The write stage drives wben/rD/valE into the register file.
//  - Keeps an 8-entry busy scoreboard of destinations issued but not yet written, for decode hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter                                                       |
// | Round-robin share of the register-file write port between EX and MEM     |
// | writeback, with a registered write stage and a destination busy board.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                nRESET,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dst,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                wben,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data
);

  logic                rr_last_q, rr_last_d;
  logic                wben_q, wben_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic w_grant0, w_grant1;
  logic w_xfer0, w_xfer1;
  logic w_issue_acc;

  // rr_last names the requester that won last; on contention the other one wins.
  assign w_grant0 = req0_valid & (~req1_valid | rr_last_q);
  assign w_grant1 = req1_valid & (~req0_valid | ~rr_last_q);

  assign req0_ready  = w_grant0 & ~flush;
  assign req1_ready  = w_grant1 & ~flush;
  assign w_xfer0     = req0_valid & req0_ready;
  assign w_xfer1     = req1_valid & req1_ready;

  assign issue_ready = ~busy_q[issue_dst] & ~flush;
  assign w_issue_acc = issue_valid & issue_ready;

  always_comb begin
    rr_last_d = rr_last_q;
    wben_d    = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (w_xfer0) begin
      rr_last_d = 1'b0;
      wben_d    = 1'b1;
      wb_addr_d = req0_addr;
      wb_data_d = req0_data;
    end else if (w_xfer1) begin
      rr_last_d = 1'b1;
      wben_d    = 1'b1;
      wb_addr_d = req1_addr;
      wb_data_d = req1_data;
    end
  end

  // Clear for the retiring write first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wben_q) begin
      busy_d[wb_addr_q] = 1'b0;
    end
    if (w_issue_acc) begin
      busy_d[issue_dst] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rr_last_q <= 1'b1;
      wben_q    <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      wben_q    <= wben_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wben    = wben_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                                    |
// | Directed bench with an arbitration/busy model and a write scoreboard.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        nRESET = 1'b0;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_dst = '0;
  logic        issue_ready;
  logic [7:0]  busy;
  logic        req0_valid = 1'b0;
  logic [2:0]  req0_addr = '0;
  logic [15:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [2:0]  req1_addr = '0;
  logic [15:0] req1_data = '0;
  logic        req1_ready;
  logic        wben;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk(clk), .nRESET(nRESET), .flush(flush),
    .issue_valid(issue_valid), .issue_dst(issue_dst), .issue_ready(issue_ready),
    .busy(busy),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req1_ready(req1_ready),
    .wben(wben), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Register file fed by the write stage.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (wben === 1'b1) rf[wb_addr] <= wb_data;
  end

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  logic        m_rr;
  logic [7:0]  m_busy;
  logic [2:0]  m_wba;
  logic [15:0] m_wbd;
  int          tests = 0;
  int          failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr   = 1'b1;
    m_busy = '0;
    m_wba  = '0;
    m_wbd  = '0;
    wq.delete();
  endtask

  // One clock: check at the falling edge, advance the model, return 1ns after the rising edge.
  task automatic step();
    logic g0, g1, r0, r1, ir;
    logic [7:0] nb;
    wr_t e;
    @(negedge clk);
    g0 = req0_valid & (~req1_valid | m_rr);
    g1 = req1_valid & (~req0_valid | ~m_rr);
    r0 = g0 & ~flush;
    r1 = g1 & ~flush;
    ir = ~m_busy[issue_dst] & ~flush;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, r0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, r1});
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, ir});
    chk("busy", {24'b0, busy}, {24'b0, m_busy});
    chk("wben", {31'b0, wben}, {31'b0, (wq.size() != 0)});
    nb = m_busy;
    if (wq.size() != 0) begin
      e     = wq.pop_front();
      m_wba = e.a;
      m_wbd = e.d;
      nb[e.a] = 1'b0;
    end
    chk("wb_addr", {29'b0, wb_addr}, {29'b0, m_wba});
    chk("wb_data", {16'b0, wb_data}, {16'b0, m_wbd});
    if (issue_valid && ir) nb[issue_dst] = 1'b1;
    if (flush) nb = '0;
    if (req0_valid && r0) begin
      wq.push_back('{a: req0_addr, d: req0_data});
      m_rr = 1'b0;
    end
    if (req1_valid && r1) begin
      wq.push_back('{a: req1_addr, d: req1_data});
      m_rr = 1'b1;
    end
    m_busy = nb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    nRESET = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wben", {31'b0, wben}, 32'd0);
    chk("rst_busy", {24'b0, busy}, 32'd0);

    // Reset in the middle of a write.
    issue_valid = 1'b1; issue_dst = 3'd6;
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 16'h1111;
    step();
    issue_valid = 1'b0; req0_valid = 1'b0;
    chk("t1_wben_pre", {31'b0, wben}, 32'd1);
    #2;
    nRESET = 1'b0;
    model_reset();
    #1;
    chk("t1_wben_rst", {31'b0, wben}, 32'd0);
    chk("t1_busy_rst", {24'b0, busy}, 32'd0);
    chk("t1_addr_rst", {29'b0, wb_addr}, 32'd0);
    chk("t1_data_rst", {16'b0, wb_data}, 32'd0);
    @(posedge clk);
    #3;
    nRESET = 1'b1;

    // Contention: alternate grants starting with req0.
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 16'hA003;
    req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 16'hB005;
    #1;
    chk("t1_first_grant", {31'b0, req0_ready}, 32'd1);
    for (int i = 0; i < 4; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    // Issue r2, MEM writes it, busy clears the edge after wben.
    issue_valid = 1'b1; issue_dst = 3'd2;
    step();
    issue_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 16'hBEEF;
    step();
    req1_valid = 1'b0;
    chk("t3_busy2_set", {31'b0, busy[2]}, 32'd1);
    step();
    chk("t3_busy2_clr", {31'b0, busy[2]}, 32'd0);
    chk("t3_rf2", {16'b0, rf[2]}, 32'h0000BEEF);

    // Same-cycle set and clear of r4, then a blocked reissue.
    req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 16'h4444;
    step();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_dst = 3'd4;
    step();
    #1;
    chk("t4_busy4", {31'b0, busy[4]}, 32'd1);
    chk("t4_issue_blocked", {31'b0, issue_ready}, 32'd0);
    step();
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 16'h0044;
    step();
    req0_valid = 1'b0;
    step();
    step();

    // Flush with busy = A5 and a pending EX request.
    issue_valid = 1'b1;
    issue_dst = 3'd0; step();
    issue_dst = 3'd2; step();
    issue_dst = 3'd5; step();
    issue_dst = 3'd7; step();
    issue_valid = 1'b0;
    chk("t5_busy_a5", {24'b0, busy}, 32'h000000A5);
    flush = 1'b1;
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 16'h6666;
    #1;
    chk("t5_ready_flush", {31'b0, req0_ready}, 32'd0);
    step();
    flush = 1'b0; req0_valid = 1'b0;
    chk("t5_busy_clr", {24'b0, busy}, 32'd0);
    chk("t5_no_wben", {31'b0, wben}, 32'd0);
    step();

    // EX alone every cycle; afterwards req1 must win contention.
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req0_addr = 3'(i + 1); req0_data = 16'h1000 + 16'(i);
      step();
      chk("t6_wben_cont", {31'b0, wben}, 32'd1);
    end
    req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 16'h7777;
    req0_addr = 3'd0; req0_data = 16'h0F0F;
    #1;
    chk("t6_rr_last0", {31'b0, req1_ready}, 32'd1);
    step();
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();
    chk("t6_rf7", {16'b0, rf[7]}, 32'h00007777);
    chk("t6_rf0", {16'b0, rf[0]}, 32'h00000F0F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
